// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for sync_fifo_param:
//   ptr_w()        width of a read/write pointer (and of the occupancy count)
//   ptr_t          pointer/count type for the default 16-entry geometry
//   DEF_*          default geometry and almost-full/almost-empty thresholds
//   is_pow2()      helper for the elaboration-time checks in the top level
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AE_THRESH = 2;
    // The default almost_full threshold sits this many entries below DEPTH.
    localparam int DEF_AF_MARGIN = 2;

    // One extra bit over the address width gives the wrap bit, which lets
    // wptr-rptr distinguish a full FIFO from an empty one.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    typedef logic [ptr_w(DEF_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Producer/consumer bus of sync_fifo_param.
//   wr, din           write request and data
//   rd                read request
//   dout, rd_valid    registered read data and its one-cycle strobe
//   count             occupancy 0..DEPTH
//   empty, full, almost_empty, almost_full   status flags
//   err_clr, overflow, underflow   sticky error flags (only with FIFO_ERR_EN)
// Modports: master = the producer/consumer side, slave = the FIFO.
// -----------------------------------------------------------------------------
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = ptr_w(DEPTH);

    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
`ifdef FIFO_ERR_EN
    logic             err_clr;
    logic             overflow;
    logic             underflow;
`endif

    modport master (
        output wr, din, rd,
`ifdef FIFO_ERR_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  dout, rd_valid, count, empty, full, almost_empty, almost_full
    );

    modport slave (
        input  wr, din, rd,
`ifdef FIFO_ERR_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output dout, rd_valid, count, empty, full, almost_empty, almost_full
    );

endinterface

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Binary pointer register with increment enable; wraps by natural rollover.
//   clk  clock
//   rst  asynchronous active-low reset, clears the pointer
//   inc  advance the pointer by one on this edge
//   ptr  current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO of DEPTH x WIDTH using every entry (no reserved slot).
// Read data is registered with one cycle of latency and qualified by rd_valid.
// A write while full is accepted when a read is accepted in the same cycle.
// All status flags decode from the registered pointers only.
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   bus   sync_fifo_param_if.slave: wr/din, rd, dout/rd_valid, count, flags
// Optional build macro FIFO_ERR_EN adds sticky overflow/underflow flags with
// a synchronous err_clr; without it illegal requests are silently ignored.
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_param_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PW     = ptr_w(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_param: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    cnt;
    logic             empty_c;
    logic             full_c;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_p1;
    logic             vld_p1;

    fifo_ptr #(.W(PW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wptr)
    );

    fifo_ptr #(.W(PW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rptr)
    );

    // Modular subtraction of the wrap-bit pointers yields 0..DEPTH directly.
    assign cnt     = wptr - rptr;
    assign empty_c = (cnt == '0);
    assign full_c  = (cnt == PW'(DEPTH));

    // No bypass: a read on an empty FIFO is rejected even if a write arrives.
    // A write while full is taken only when the read frees the oldest slot.
    assign rd_acc = bus.rd && !empty_c;
    assign wr_acc = bus.wr && (!full_c || rd_acc);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ADDR_W-1:0]] <= bus.din;
        end
    end

    // ---- stage p1: registered read data and its valid strobe ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                dout_p1 <= mem[rptr[ADDR_W-1:0]];
            end
        end
    end

    assign bus.dout         = dout_p1;
    assign bus.rd_valid     = vld_p1;
    assign bus.count        = cnt;
    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.almost_empty = (cnt <= PW'(AE_THRESH));
    assign bus.almost_full  = (cnt >= PW'(AF_THRESH));

`ifdef FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Set is evaluated after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (bus.wr && full_c && !bus.rd) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd && empty_c) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16, AF=14, AE=2).
// A queue-based reference model tracks accepted reads/writes; each scenario
// task drives stimulus and compares DUT outputs against the model inline.
// Builds with or without FIFO_ERR_EN.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
`ifdef FIFO_ERR_EN
    logic             m_ovf;
    logic             m_unf;
    logic             clr_in;
`endif

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) b ();

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
`ifdef FIFO_ERR_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, then
    // leave the bus idle and return 1 time unit after the edge.
    task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit rok;
        bit wok;
        bit was_full;
        b.wr  = w;
        b.din = d;
        b.rd  = r;
`ifdef FIFO_ERR_EN
        b.err_clr = clr_in;
`endif
        @(posedge clk);
        was_full = (q.size() == DEPTH);
        rok = r && (q.size() != 0);
        wok = w && (!was_full || rok);
`ifdef FIFO_ERR_EN
        if (clr_in) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && was_full && !r) m_ovf = 1'b1;
        if (r && q.size() == 0)  m_unf = 1'b1;
`endif
        m_vld = rok;
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
        #1;
        b.wr = 1'b0;
        b.rd = 1'b0;
`ifdef FIFO_ERR_EN
        clr_in    = 1'b0;
        b.err_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        b.wr = 1'b1;
        b.rd = 1'b1;
        b.din = 8'h77;
`ifdef FIFO_ERR_EN
        clr_in    = 1'b0;
        b.err_clr = 1'b0;
`endif
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            nvec++;
            if (b.empty !== 1'b1 || b.full !== 1'b0 || b.count !== ptr_t'(0)) begin
                nerr++;
                $display("FAIL reset_flags: empty=%b full=%b count=%0d want 1 0 0",
                         b.empty, b.full, b.count);
            end
            nvec++;
            if (b.dout !== 8'h00 || b.rd_valid !== 1'b0) begin
                nerr++;
                $display("FAIL reset_dout: dout=%h rd_valid=%b want 00 0", b.dout, b.rd_valid);
            end
            nvec++;
            if (b.almost_empty !== 1'b1 || b.almost_full !== 1'b0) begin
                nerr++;
                $display("FAIL reset_almost: ae=%b af=%b want 1 0", b.almost_empty, b.almost_full);
            end
        end
        @(negedge clk);
        b.wr = 1'b0;
        b.rd = 1'b0;
        rst  = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0);
            nvec++;
            if (b.count !== ptr_t'(i + 1) || b.count !== ptr_t'(q.size())) begin
                nerr++;
                $display("FAIL fill_count: got %0d want %0d", b.count, i + 1);
            end
            nvec++;
            if (b.almost_full !== (i + 1 >= AF) || b.full !== (i + 1 == DEPTH)) begin
                nerr++;
                $display("FAIL fill_flags: af=%b full=%b at count %0d", b.almost_full, b.full, i + 1);
            end
        end
        drive(1'b1, 8'hAA, 1'b0);
        nvec++;
        if (b.count !== ptr_t'(DEPTH) || b.full !== 1'b1) begin
            nerr++;
            $display("FAIL overfill: count=%0d full=%b want 16 1", b.count, b.full);
        end
`ifdef FIFO_ERR_EN
        nvec++;
        if (b.overflow !== 1'b1) begin
            nerr++;
            $display("FAIL overflow_set: got %b want 1", b.overflow);
        end
        clr_in = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            nvec++;
            if (b.rd_valid !== 1'b1 || b.dout !== m_dout || b.dout !== 8'(8'h10 + i)) begin
                nerr++;
                $display("FAIL drain_data: vld=%b dout=%h want 1 %h", b.rd_valid, b.dout, 8'(8'h10 + i));
            end
            nvec++;
            if (b.count !== ptr_t'(q.size()) || b.almost_empty !== (q.size() <= AE)) begin
                nerr++;
                $display("FAIL drain_count: count=%0d ae=%b want %0d", b.count, b.almost_empty, q.size());
            end
        end
        nvec++;
        if (b.empty !== 1'b1) begin
            nerr++;
            $display("FAIL drain_empty: got %b want 1", b.empty);
        end
    endtask

    task automatic test_read_empty();
        drive(1'b0, 8'h00, 1'b1);
        nvec++;
        if (b.dout !== 8'h1F || b.rd_valid !== 1'b0 || b.count !== ptr_t'(0)) begin
            nerr++;
            $display("FAIL rd_empty: dout=%h vld=%b count=%0d want 1f 0 0", b.dout, b.rd_valid, b.count);
        end
`ifdef FIFO_ERR_EN
        nvec++;
        if (b.underflow !== 1'b1) begin
            nerr++;
            $display("FAIL underflow_set: got %b want 1", b.underflow);
        end
        clr_in = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        nvec++;
        if (b.underflow !== 1'b0 || b.overflow !== 1'b0) begin
            nerr++;
            $display("FAIL err_clr: unf=%b ovf=%b want 0 0", b.underflow, b.overflow);
        end
`endif
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b1);
            nvec++;
            if (b.count !== ptr_t'(DEPTH) || b.full !== 1'b1) begin
                nerr++;
                $display("FAIL full_rw_count: count=%0d full=%b want 16 1", b.count, b.full);
            end
            nvec++;
            if (b.rd_valid !== 1'b1 || b.dout !== m_dout) begin
                nerr++;
                $display("FAIL full_rw_data: vld=%b dout=%h want 1 %h", b.rd_valid, b.dout, m_dout);
            end
        end
`ifdef FIFO_ERR_EN
        nvec++;
        if (b.overflow !== 1'b0) begin
            nerr++;
            $display("FAIL full_rw_ovf: got %b want 0", b.overflow);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            nvec++;
            if (b.rd_valid !== 1'b1 || b.dout !== m_dout ||
                (i >= 12 && b.dout !== 8'(8'h50 + i - 12))) begin
                nerr++;
                $display("FAIL full_rw_drain: i=%0d dout=%h want %h", i, b.dout, m_dout);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 8'($urandom), 1'b1);
            nvec++;
            if (b.count !== ptr_t'(3) || b.rd_valid !== 1'b1 || b.dout !== m_dout) begin
                nerr++;
                $display("FAIL wrap: count=%0d vld=%b dout=%h want 3 1 %h", b.count, b.rd_valid, b.dout, m_dout);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            nvec++;
            if (b.dout !== m_dout) begin
                nerr++;
                $display("FAIL wrap_drain: dout=%h want %h", b.dout, m_dout);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic r;
            // Alternate the bias so the run visits both full and empty.
            if ((i / 50) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
`ifdef FIFO_ERR_EN
            clr_in = ($urandom_range(0, 15) == 0);
`endif
            drive(w, 8'($urandom), r);
            nvec++;
            if (b.count !== ptr_t'(q.size()) || b.empty !== (q.size() == 0) ||
                b.full !== (q.size() == DEPTH) || b.almost_empty !== (q.size() <= AE) ||
                b.almost_full !== (q.size() >= AF)) begin
                nerr++;
                $display("FAIL rand_status: cyc=%0d count=%0d e=%b f=%b ae=%b af=%b want count %0d",
                         i, b.count, b.empty, b.full, b.almost_empty, b.almost_full, q.size());
            end
            nvec++;
            if (b.rd_valid !== m_vld || b.dout !== m_dout) begin
                nerr++;
                $display("FAIL rand_data: cyc=%0d vld=%b dout=%h want %b %h", i, b.rd_valid, b.dout, m_vld, m_dout);
            end
`ifdef FIFO_ERR_EN
            nvec++;
            if (b.overflow !== m_ovf || b.underflow !== m_unf) begin
                nerr++;
                $display("FAIL rand_err: cyc=%0d ovf=%b unf=%b want %b %b", i, b.overflow, b.underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        while (q.size() != 0) drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b1, 8'h3C, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        nvec++;
        if (b.count !== ptr_t'(9) || b.rd_valid !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset: count=%0d vld=%b want 9 1", b.count, b.rd_valid);
        end
        b.wr = 1'b1;
        b.rd = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (b.count !== ptr_t'(0) || b.empty !== 1'b1 || b.rd_valid !== 1'b0 || b.dout !== 8'h00) begin
            nerr++;
            $display("FAIL async_reset: count=%0d empty=%b vld=%b dout=%h want 0 1 0 00",
                     b.count, b.empty, b.rd_valid, b.dout);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (b.rd_valid !== 1'b0 || b.count !== ptr_t'(0)) begin
            nerr++;
            $display("FAIL reset_edge: vld=%b count=%0d want 0 0", b.rd_valid, b.count);
        end
        @(negedge clk);
        b.wr = 1'b0;
        b.rd = 1'b0;
        rst  = 1'b1;
        drive(1'b1, 8'h99, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        nvec++;
        if (b.rd_valid !== 1'b1 || b.dout !== 8'h99 || b.empty !== 1'b1) begin
            nerr++;
            $display("FAIL post_reset: vld=%b dout=%h empty=%b want 1 99 1", b.rd_valid, b.dout, b.empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_read_empty();
        test_full_rw();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next generation of the team's 16x8 FIFO. Generalised in WIDTH and DEPTH. Uses all DEPTH entries, with no reserved slot. Supports simultaneous read and write, including a write while full. Adds occupancy count, programmable almost-full/almost-empty flags and a read-valid strobe. Sits between producer/consumer blocks on the same clock.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 16, number of entries; power of 2, >= 4
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wr  in  1  write request
din  in  WIDTH  write data
rd  in  1  read request
dout  out  WIDTH  registered read data
rd_valid  out  1  dout updated this cycle by an accepted read
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
almost_empty  out  1  count<=AE_THRESH
almost_full  out  1  count>=AF_THRESH
err_clr  in  1  clears sticky error flags (FIFO_ERR_EN only)
overflow  out  1  sticky, dropped write (FIFO_ERR_EN only)
underflow  out  1  sticky, rejected read (FIFO_ERR_EN only)

Behaviour:
- Reset (rst=0, async assert, sync deassert expected upstream):
  - wptr=rptr=0, dout=0, rd_valid=0, overflow=underflow=0.
  - Hence count=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- Pointers are ADDR_W+1 bits, where ADDR_W=$clog2(DEPTH). The MSB is the wrap bit; the low bits address memory. Wrap is natural binary rollover, with no explicit compare.
- count=wptr-rptr, modulo 2^(ADDR_W+1). All flags decode combinationally from registered pointers only; there is no din/wr/rd to flag path.
- rd_acc = rd && !empty.
- wr_acc = wr && (!full || rd_acc).
- Accepted write: mem[wptr[ADDR_W-1:0]] <= din; wptr+1. New data is visible to rd from the next cycle.
- Accepted read: dout <= mem[rptr[ADDR_W-1:0]]; rptr+1; rd_valid=1 in the following cycle, aligned with the new dout. Read latency is 1 cycle.
- Rejected read: dout holds its value, rd_valid=0, rptr unchanged.
- Rejected write: memory and wptr unchanged.
- Simultaneous read and write:
  - Not full, not empty: both accepted, count unchanged.
  - Empty: write accepted, read rejected (no bypass); count becomes 1.
  - Full: both accepted, count stays DEPTH; the read returns the oldest entry.
- Flags after a boundary operation settle in the cycle after the edge that changed count.
- Reset mid-operation: all state is cleared immediately, and any in-flight rd_valid is dropped.

Optional Feature:
FIFO_ERR_EN
- Defined: overflow and underflow ports and logic are present.
  - overflow sets on wr && full && !rd.
  - underflow sets on rd && empty.
  - Both are sticky until err_clr=1 at a clock edge (sync clear) or reset.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Undefined: err_clr, overflow and underflow ports and logic are absent. Illegal requests are still silently ignored as above.

Decomposition:
- Package fifo_pkg holds:
  - the function ptr_w(DEPTH) = $clog2(DEPTH)+1;
  - a typedef for the pointer/count type;
  - localparam default thresholds;
  - elaboration-time checks: DEPTH power of 2, and AE_THRESH < AF_THRESH <= DEPTH.
- One sub-module, fifo_ptr: pointer register with async active-low reset and increment enable, instantiated twice (write and read). The memory array and flag decode stay in the top level.

Test Plan (WIDTH=8, DEPTH=16, AF=14, AE=2):
- Reset with rd=1 and wr=1 held, then release: empty=1, full=0, count=0, dout=0, rd_valid=0 throughout reset.
- 16 writes of 0x10..0x1F: full=1 after the 16th; almost_full rises when count=14. A 17th write of 0xAA is dropped (overflow=1 with macro). Then 16 reads return 0x10..0x1F in order, each with rd_valid one cycle after rd; empty=1 after the last.
- Read on empty: dout holds its last value, rd_valid=0, count stays 0, underflow=1 with macro. err_clr pulse -> underflow=0.
- Fill to 16, then wr=rd=1 for 4 cycles with 0x50..0x53: count stays 16, reads return the 4 oldest entries, full stays 1. Draining then yields the remaining 12 old entries followed by 0x50..0x53.
- Wrap: 24 write/read cycles at count 3; data stays in order across the pointer wrap; count stays 3.
- Assert rst at count=9 mid-burst: count=0 and empty=1 asynchronously, before the next edge; no rd_valid after the reset edge.
